// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// A fetch packet pairs an instruction word with the PC it was fetched from.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_pkt_t;

  localparam int PKT_W = $bits(fetch_pkt_t);

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; used both as the prefetch buffer and as
// the in-flight PC tag queue. Head is read combinationally from the array.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // A push into a full FIFO is only accepted when a pop frees a slot the same cycle.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push && !flush && !reset) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        if (r_wr_ptr == PW'(DEPTH - 1)) r_wr_ptr <= '0;
        else                            r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        if (r_rd_ptr == PW'(DEPTH - 1)) r_rd_ptr <= '0;
        else                            r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC generation, in-order memory responses
// tagged with their PC, a prefetch buffer to decode and redirect handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_drop_count;

  logic            w_req_fire;
  logic            w_out_fire;
  logic            w_resp_live;
  logic            w_resp_drop;
  logic [XLEN-1:0] w_tag_pc;
  logic            w_tag_full;
  logic            w_tag_empty;
  logic [CW-1:0]   w_live_count;
  fetch_pkt_t      w_resp_pkt;
  fetch_pkt_t      w_head_pkt;
  logic            w_buf_full;
  logic            w_buf_empty;
  logic [CW-1:0]   w_buf_count;
  logic [CW:0]     w_live_plus_buf;
  logic [CW:0]     w_live_plus_drop;

  assign w_live_plus_buf  = {1'b0, w_live_count} + {1'b0, w_buf_count};
  assign w_live_plus_drop = {1'b0, w_live_count} + {1'b0, r_drop_count};

  // Full flags are implied by the count limits; kept as explicit guards.
  assign imem_req_valid = !reset && !redirect_valid && !w_tag_full && !w_buf_full &&
                          (w_live_plus_buf  < (CW+1)'(DEPTH)) &&
                          (w_live_plus_drop < (CW+1)'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // Responses belong to dropped requests first, since memory answers in order.
  assign w_resp_live = imem_resp_valid && !reset && !redirect_valid &&
                       (r_drop_count == '0) && !w_tag_empty;
  assign w_resp_drop = imem_resp_valid && !reset && !redirect_valid &&
                       (r_drop_count != '0);

  assign w_resp_pkt = '{pc: w_tag_pc, instr: imem_resp_data};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_tag_q (
    .clk   (clk),
    .reset (reset),
    .push  (w_req_fire),
    .din   (r_fetch_pc),
    .pop   (w_resp_live),
    .flush (redirect_valid),
    .dout  (w_tag_pc),
    .full  (w_tag_full),
    .empty (w_tag_empty),
    .count (w_live_count)
  );

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PKT_W)
  ) u_prefetch_buf (
    .clk   (clk),
    .reset (reset),
    .push  (w_resp_live),
    .din   (w_resp_pkt),
    .pop   (w_out_fire),
    .flush (redirect_valid),
    .dout  (w_head_pkt),
    .full  (w_buf_full),
    .empty (w_buf_empty),
    .count (w_buf_count)
  );

  assign out_valid  = !reset && !w_buf_empty;
  assign out_pc     = out_valid ? w_head_pkt.pc    : '0;
  assign out_instr  = out_valid ? w_head_pkt.instr : '0;
  assign w_out_fire = out_valid && out_ready;

  // On redirect every live request becomes a drop; a response landing in the
  // same cycle retires one of the outstanding requests immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc   <= RESET_PC;
      r_drop_count <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc   <= align_word(redirect_pc);
      r_drop_count <= r_drop_count + w_live_count - CW'(imem_resp_valid);
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      if (w_resp_drop) begin
        r_drop_count <= r_drop_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and random checks of fetch_unit against a stream-level model:
// requests and outputs must follow consecutive word addresses from the last restart.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       mq[$];
  logic [31:0] req_log[$];
  logic [31:0] out_log[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  bit          rdy_rand = 0;
  bit          ordy_rand = 0;
  bit          ordy_val = 1;
  bit          verbose = 1;
  logic [31:0] exp_req_pc = RESET_PC;
  logic [31:0] exp_out_pc = RESET_PC;
  bit          after_redirect = 0;
  bit          prev_hold = 0;
  logic [31:0] prev_addr = '0;
  bit          last_out_valid = 0;
  bit          last_both = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check settled outputs, advance the model.
  task automatic tick(input bit rst, input bit redir, input logic [31:0] rpc);
    bit    rf;
    bit    of;
    pend_t p;
    reset           = rst;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    imem_req_ready  = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    out_ready       = ordy_rand ? ($urandom_range(0, 1) == 1) : ordy_val;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq[0].addr);
    end
    #1;
    rf = imem_req_valid && imem_req_ready;
    of = out_valid && out_ready;
    last_out_valid = out_valid;
    last_both = of && imem_resp_valid;
    if (rst) begin
      check("rst_req_valid", 32'(imem_req_valid), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_pc", out_pc, 0);
      check("rst_out_instr", out_instr, 0);
    end else begin
      if (after_redirect) check("flushed_out_valid", 32'(out_valid), 0);
      if (redir) check("redirect_req_valid", 32'(imem_req_valid), 0);
      if (prev_hold && !redir) begin
        check("hold_req_valid", 32'(imem_req_valid), 1);
        check("hold_req_addr", imem_req_addr, prev_addr);
      end
      if (imem_req_valid) check("req_addr", imem_req_addr, exp_req_pc);
      if (out_valid) begin
        check("out_pc", out_pc, exp_out_pc);
        check("out_instr", out_instr, mem_word(exp_out_pc));
      end
    end
    if (imem_resp_valid) void'(mq.pop_front());
    if (rst) begin
      mq.delete();
      exp_req_pc     = RESET_PC;
      exp_out_pc     = RESET_PC;
      after_redirect = 0;
      prev_hold      = 0;
    end else begin
      if (rf) begin
        if (verbose) $display("cyc %0d req addr=%h", cyc, imem_req_addr);
        req_log.push_back(imem_req_addr);
        p.addr = imem_req_addr;
        p.due  = cyc + int'($urandom_range(lat_lo, lat_hi));
        mq.push_back(p);
        exp_req_pc += 32'd4;
      end
      if (of) begin
        if (verbose) $display("cyc %0d out pc=%h instr=%h", cyc, out_pc, out_instr);
        out_log.push_back(out_pc);
        exp_out_pc += 32'd4;
      end
      if (redir) begin
        exp_req_pc = rpc & ~32'h3;
        exp_out_pc = rpc & ~32'h3;
      end
      after_redirect = redir;
      prev_hold = imem_req_valid && !imem_req_ready && !redir;
      prev_addr = imem_req_addr;
      check("outstanding_bound", 32'(mq.size() <= DEPTH), 1);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_logs();
    req_log.delete();
    out_log.delete();
  endtask

  initial begin
    reset = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    @(negedge clk);

    // Latency 1, decode always ready: 0x0, 0x4, 0x8 in order.
    lat_lo = 1; lat_hi = 1; ordy_val = 1;
    repeat (2) tick(1, 0, 0);
    clear_logs();
    tick(0, 0, 0);
    tick(0, 0, 0);
    check("resp_not_combinational", 32'(last_out_valid), 0);
    check("out_valid_after_resp", 32'(out_valid), 1);
    repeat (12) tick(0, 0, 0);
    check("seq_len", 32'(out_log.size() >= 3), 1);
    if (out_log.size() >= 3) begin
      check("seq_pc0", out_log[0], 32'h0);
      check("seq_pc1", out_log[1], 32'h4);
      check("seq_pc2", out_log[2], 32'h8);
    end

    // Decode stalled: two requests only, head holds word for 0x0.
    repeat (2) tick(1, 0, 0);
    ordy_val = 0;
    clear_logs();
    repeat (10) tick(0, 0, 0);
    check("stall_req_count", req_log.size(), 2);
    if (req_log.size() == 2) begin
      check("stall_req0", req_log[0], 32'h0);
      check("stall_req1", req_log[1], 32'h4);
    end
    check("stall_req_valid", 32'(imem_req_valid), 0);
    check("stall_out_valid", 32'(out_valid), 1);
    check("stall_out_instr", out_instr, mem_word(32'h0));
    repeat (4) tick(0, 0, 0);
    check("stall_out_instr_stable", out_instr, mem_word(32'h0));

    // Reset with the buffer full, then restart at RESET_PC.
    tick(1, 0, 0);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_req_valid", 32'(imem_req_valid), 0);
    ordy_val = 1;
    clear_logs();
    tick(0, 0, 0);
    check("midrst_restart_len", req_log.size(), 1);
    if (req_log.size() == 1) check("midrst_restart_addr", req_log[0], RESET_PC);

    // Redirect to 0x103 with two requests in flight at latency 3.
    repeat (2) tick(1, 0, 0);
    lat_lo = 3; lat_hi = 3;
    clear_logs();
    tick(0, 0, 0);
    tick(0, 0, 0);
    check("inflight_count", req_log.size(), 2);
    tick(0, 1, 32'h103);
    clear_logs();
    repeat (16) tick(0, 0, 0);
    check("redir_req_len", 32'(req_log.size() >= 1), 1);
    check("redir_out_len", 32'(out_log.size() >= 1), 1);
    if (req_log.size() >= 1) check("redir_first_req", req_log[0], 32'h100);
    if (out_log.size() >= 1) check("redir_first_out", out_log[0], 32'h100);

    // Redirect coinciding with an output fire and a response.
    repeat (2) tick(1, 0, 0);
    lat_lo = 1; lat_hi = 1;
    clear_logs();
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 1, 32'h200);
    check("triple_event", 32'(last_both), 1);
    tick(0, 0, 0);
    check("triple_flush", 32'(last_out_valid), 0);
    repeat (10) tick(0, 0, 0);
    check("triple_out_len", 32'(out_log.size() >= 2), 1);
    if (out_log.size() >= 2) begin
      check("triple_consumed", out_log[0], 32'h0);
      check("triple_next", out_log[1], 32'h200);
    end

    // Address wrap.
    tick(0, 1, 32'hFFFF_FFFC);
    clear_logs();
    repeat (8) tick(0, 0, 0);
    check("wrap_len", 32'(req_log.size() >= 2), 1);
    if (req_log.size() >= 2) begin
      check("wrap_req0", req_log[0], 32'hFFFF_FFFC);
      check("wrap_req1", req_log[1], 32'h0000_0000);
    end

    // Random traffic: backpressure, latency 1..4, redirects and resets.
    verbose = 0; rdy_rand = 1; ordy_rand = 1; lat_lo = 1; lat_hi = 4;
    repeat (2) tick(1, 0, 0);
    clear_logs();
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 499) == 0, $urandom_range(0, 29) == 0, $urandom);
    end
    check("random_progress", 32'(out_log.size() > 100), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
